equiv_check_sequencer: RTL
==========================

Name: equiv_check_sequencer

Overview:
Self-running stimulus and compare controller for the dual-instance equivalence harness. It generates pseudo-random input vectors for the two candidate designs (wire3/wire2/wire1/wire0) and waits a fixed settle time. It then compares the two 91-bit outputs and accumulates a pass/fail verdict with mismatch statistics. It replaces the per-cycle free-running assertion with a sequenced, countable check that simulation and FPGA-emulation runs can read back.

Parameters:
OUT_W, 91, width of each compared output (y_1/y_2).
SETTLE, 2, cycles between applying a vector and sampling outputs (≥1; covers DUT register depth).
VEC_W, 16, width of vector count / index.
CNT_W, 16, width of mismatch counter (saturating).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run (sampled in IDLE or DONE)
abort  in  1  terminate run, return to IDLE
stop_on_fail  in  1  end run at first mismatch (sampled at start)
seed  in  32  LFSR seed (sampled at start; 0 replaced by 32'h1)
num_vec  in  VEC_W  vectors to apply (sampled at start)
wire3  out  10  stimulus to both DUTs
wire2  out  7  stimulus to both DUTs
wire1  out  6 signed  stimulus to both DUTs
wire0  out  6 signed  stimulus to both DUTs
y_1  in  OUT_W  output of instance 1
y_2  in  OUT_W  output of instance 2
busy  out  1  run in progress
done  out  1  run finished; held until next start/abort
pass  out  1  valid when done: mismatch_cnt==0
mismatch_cnt  out  CNT_W  saturating count of failing vectors
first_fail_idx  out  VEC_W  index of first failing vector
first_fail_vld  out  1  first_fail_idx valid

Behaviour:
- Reset (async, rst_n=0): state IDLE, lfsr=32'h1, all outputs 0 (stimulus outputs = slices of lfsr=1, i.e. wire3=10'h001, others 0).
- Stimulus is combinational from the registered lfsr: wire3=lfsr[9:0], wire2=lfsr[16:10], wire1=lfsr[22:17], wire0=lfsr[28:23].
- LFSR: 32-bit Galois, taps 32'h80200003, shifts right one step per vector, only on leaving COMPARE.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE/DONE + start: load lfsr, vec_idx=0, settle_cnt=0, mismatch_cnt=0, first_fail_vld=0, done=0, busy=1. If num_vec==0, go to DONE with pass=1; otherwise go to SETTLE.
- SETTLE: count SETTLE cycles, then COMPARE.
- COMPARE (one cycle): mismatch when y_1!=y_2 (full OUT_W, bitwise). On mismatch:
  - mismatch_cnt++ (saturates at all-ones).
  - If !first_fail_vld, capture first_fail_idx=vec_idx and set first_fail_vld.
- Leaving COMPARE:
  - If mismatch && stop_on_fail, or vec_idx==num_vec-1: go to DONE.
  - Otherwise advance lfsr, vec_idx++, go to SETTLE.
- Per-vector period: SETTLE+1 cycles. First compare occurs SETTLE+1 cycles after the start edge.
- DONE: busy=0, done=1, pass=(mismatch_cnt==0). Counters held.
- abort (any state, priority over start): go to IDLE next edge. busy=0, done=0; counters held for debug.
- start while busy: ignored.
- rst_n asserted mid-run: immediate return to reset values, no partial verdict.

Decomposition:
- Package equiv_pkg: state enum, LFSR_TAPS constant, stimulus slice bit positions, default OUT_W.
- One sub-module: equiv_lfsr32, with load/seed/step inputs and a 32-bit state output. The FSM and counters stay in the parent.

Test Plan:
- Reset, then start with seed=0, num_vec=4, SETTLE=2, y_1==y_2 tied → busy for 12 cycles; done=1, pass=1, mismatch_cnt=0, first_fail_vld=0. Verify that a seed of 0 is applied as 32'h1.
- Force y_2=y_1^1 on vector 2 only, num_vec=5, stop_on_fail=0 → done, pass=0, mismatch_cnt=1, first_fail_idx=2.
- Same as the previous scenario with stop_on_fail=1 → done after vector 2's compare (9 cycles from start), vec_idx=2.
- Permanently unequal outputs, CNT_W=4, num_vec=20 → mismatch_cnt saturates at 15, first_fail_idx=0.
- Run with seed=32'hDEADBEEF and check wire3..wire0 across 3 vectors against a reference Galois LFSR model. Pulse abort mid-SETTLE → IDLE next cycle, done=0.
- Assert rst_n low during COMPARE → all outputs return to reset values asynchronously. A subsequent start runs normally.

Source files
------------

// File: rtl/equiv_check_sequencer_pkg.sv
// ============================================================================
// Module      : equiv_pkg
// Description : Shared types and constants for the equivalence-check
//               sequencer: FSM state encoding, LFSR taps and the bit
//               positions of the stimulus slices taken from the LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package equiv_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Galois feedback polynomial and the non-zero reset/seed-substitute value
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

    // Stimulus slices of the LFSR state
    localparam int W3_LSB = 0;
    localparam int W3_W   = 10;
    localparam int W2_LSB = 10;
    localparam int W2_W   = 7;
    localparam int W1_LSB = 17;
    localparam int W1_W   = 6;
    localparam int W0_LSB = 23;
    localparam int W0_W   = 6;

    // Width of the compared outputs of the two candidate designs
    localparam int DEFAULT_OUT_W = 91;

    // One right-shift step of the Galois LFSR
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/equiv_check_sequencer_if.sv
// ============================================================================
// Module      : equiv_check_sequencer_if
// Description : Control, status, stimulus and response bundle between the
//               equivalence-check sequencer (slave) and the harness (master).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface equiv_check_sequencer_if
    import equiv_pkg::*;
#(
    parameter int OUT_W = DEFAULT_OUT_W,
    parameter int VEC_W = 16,
    parameter int CNT_W = 16
);
    // Run control
    logic                     start;
    logic                     abort;
    logic                     stop_on_fail;
    logic [31:0]              seed;
    logic [VEC_W-1:0]         num_vec;
    // Stimulus to both candidate designs
    logic [W3_W-1:0]          wire3;
    logic [W2_W-1:0]          wire2;
    logic signed [W1_W-1:0]   wire1;
    logic signed [W0_W-1:0]   wire0;
    // Responses of the two candidate designs
    logic [OUT_W-1:0]         y_1;
    logic [OUT_W-1:0]         y_2;
    // Verdict and statistics
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [CNT_W-1:0]         mismatch_cnt;
    logic [VEC_W-1:0]         first_fail_idx;
    logic                     first_fail_vld;

    modport master (
        output start, abort, stop_on_fail, seed, num_vec, y_1, y_2,
        input  wire3, wire2, wire1, wire0,
        input  busy, done, pass, mismatch_cnt, first_fail_idx, first_fail_vld
    );

    modport slave (
        input  start, abort, stop_on_fail, seed, num_vec, y_1, y_2,
        output wire3, wire2, wire1, wire0,
        output busy, done, pass, mismatch_cnt, first_fail_idx, first_fail_vld
    );

endinterface

`default_nettype wire

// File: rtl/equiv_check_sequencer_lfsr32.sv
// ============================================================================
// Module      : equiv_lfsr32
// Description : 32-bit right-shifting Galois LFSR with seed load. A zero
//               seed is replaced by 1 so the register never locks up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module equiv_lfsr32
    import equiv_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        load,
    input  wire logic [31:0] seed,
    input  wire logic        step,
    output logic      [31:0] state
);

    logic [31:0] r_state;

    // Load has priority over step; otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LFSR_RESET;
        end else if (load) begin
            r_state <= (seed == 32'h0) ? LFSR_RESET : seed;
        end else if (step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: rtl/equiv_check_sequencer.sv
// ============================================================================
// Module      : equiv_check_sequencer
// Description : Applies LFSR-generated vectors to two candidate designs,
//               waits a settle time, compares their outputs and accumulates
//               a pass/fail verdict with mismatch statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module equiv_check_sequencer
    import equiv_pkg::*;
#(
    parameter int OUT_W  = DEFAULT_OUT_W,
    parameter int SETTLE = 2,
    parameter int VEC_W  = 16,
    parameter int CNT_W  = 16
)(
    input  wire logic               clk,
    input  wire logic               rst_n,
    equiv_check_sequencer_if.slave  bus
);

    localparam int              SC_W        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);

    state_t             r_state;
    logic [SC_W-1:0]    r_settle_cnt;
    logic [VEC_W-1:0]   r_vec_idx;
    logic [VEC_W-1:0]   r_num_vec;
    logic               r_stop_on_fail;
    logic [CNT_W-1:0]   r_mismatch_cnt;
    logic [VEC_W-1:0]   r_first_fail_idx;
    logic               r_first_fail_vld;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic               w_idle_like;
    logic               w_mismatch;
    logic               w_last;
    logic               w_load;
    logic               w_step;
    logic [31:0]        w_lfsr;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_mismatch  = (bus.y_1 != bus.y_2);
    // Run ends on the final vector, or on the first failure when requested
    assign w_last      = (w_mismatch && r_stop_on_fail) ||
                         (r_vec_idx == r_num_vec - VEC_W'(1));
    assign w_load      = !bus.abort && w_idle_like && bus.start;
    assign w_step      = !bus.abort && (r_state == ST_COMPARE) && !w_last;

    equiv_lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .seed  (bus.seed),
        .step  (w_step),
        .state (w_lfsr)
    );

    // Sequencer FSM with counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_settle_cnt     <= '0;
            r_vec_idx        <= '0;
            r_num_vec        <= '0;
            r_stop_on_fail   <= 1'b0;
            r_mismatch_cnt   <= '0;
            r_first_fail_idx <= '0;
            r_first_fail_vld <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
        end else if (bus.abort) begin
            // Counters are left untouched so they can be inspected
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_settle_cnt     <= '0;
                        r_vec_idx        <= '0;
                        r_num_vec        <= bus.num_vec;
                        r_stop_on_fail   <= bus.stop_on_fail;
                        r_mismatch_cnt   <= '0;
                        r_first_fail_vld <= 1'b0;
                        if (bus.num_vec == '0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_SETTLE;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_settle_cnt <= '0;
                        r_state      <= ST_COMPARE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SC_W'(1);
                    end
                end
                ST_COMPARE: begin
                    if (w_mismatch) begin
                        if (!(&r_mismatch_cnt)) begin
                            r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
                        end
                        if (!r_first_fail_vld) begin
                            r_first_fail_idx <= r_vec_idx;
                            r_first_fail_vld <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_mismatch_cnt == '0) && !w_mismatch;
                    end else begin
                        r_vec_idx <= r_vec_idx + VEC_W'(1);
                        r_state   <= ST_SETTLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.wire3          = w_lfsr[W3_LSB +: W3_W];
    assign bus.wire2          = w_lfsr[W2_LSB +: W2_W];
    assign bus.wire1          = $signed(w_lfsr[W1_LSB +: W1_W]);
    assign bus.wire0          = $signed(w_lfsr[W0_LSB +: W0_W]);
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.mismatch_cnt   = r_mismatch_cnt;
    assign bus.first_fail_idx = r_first_fail_idx;
    assign bus.first_fail_vld = r_first_fail_vld;

endmodule

`default_nettype wire
